// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MDU_WAIT = 2'd1,
        MEM_WAIT = 2'd2
    } hazard_state_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/fwd_unit.sv
// E-stage operand forwarding select for one source register; M beats W, x0 never forwards.
module fwd_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs_e,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              regwrite_m,
    input  logic              regwrite_w,
    output logic [1:0]        sel
);

    logic hit_m_s;
    logic hit_w_s;

    assign hit_m_s = regwrite_m && (rd_m != {REG_AW{1'b0}}) && (rd_m == rs_e);
    assign hit_w_s = regwrite_w && (rd_w != {REG_AW{1'b0}}) && (rd_w == rs_e);

    // Priority select between the two bypass sources
    always_comb begin
        sel = FWD_RF;
        if (hit_m_s) begin
            sel = FWD_M;
        end else if (hit_w_s) begin
            sel = FWD_W;
        end else begin
            sel = FWD_RF;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stalls, flushes, forwarding and MDU/memory wait sequencing.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] rs1D,
    input  logic [REG_AW-1:0] rs2D,
    input  logic [REG_AW-1:0] rs1E,
    input  logic [REG_AW-1:0] rs2E,
    input  logic [REG_AW-1:0] rdE,
    input  logic [REG_AW-1:0] rdM,
    input  logic [REG_AW-1:0] rdW,
    input  logic              loadE,
    input  logic              regwriteM,
    input  logic              regwriteW,
    input  logic              pcsrcE,
    input  logic              mduE,
    input  logic              mdu_done,
    input  logic              dmem_reqM,
    input  logic              dmem_readyM,
    output logic              mdu_start,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              stallM,
    output logic              flushD,
    output logic              flushE,
    output logic              flushM,
    output logic              flushW,
    output logic [1:0]        fwdAE,
    output logic [1:0]        fwdBE,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_count
);

    hazard_state_t state_r;
    logic memstall_s;
    logic lwstall_s;
    logic run_s;
    logic mdu_hold_s;
    logic mem_hold_s;
    logic start_s;

    assign memstall_s = dmem_reqM && !dmem_readyM;
    assign lwstall_s  = loadE && (rdE != {REG_AW{1'b0}}) && ((rdE == rs1D) || (rdE == rs2D));

    // State register with next-state selection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= RUN;
        end else begin
            case (state_r)
                RUN: begin
                    if (memstall_s)  state_r <= MEM_WAIT;
                    else if (mduE)   state_r <= MDU_WAIT;
                    else             state_r <= RUN;
                end
                MDU_WAIT: state_r <= mdu_done    ? RUN : MDU_WAIT;
                MEM_WAIT: state_r <= dmem_readyM ? RUN : MEM_WAIT;
                default:  state_r <= RUN;
            endcase
        end
    end

    // Per-state hold conditions; in RUN a memory stall overrides every other hazard
    always_comb begin
        run_s      = 1'b0;
        mdu_hold_s = 1'b0;
        mem_hold_s = 1'b0;
        case (state_r)
            RUN: begin
                run_s      = !memstall_s;
                mem_hold_s = memstall_s;
            end
            MDU_WAIT: mdu_hold_s = !mdu_done;
            MEM_WAIT: mem_hold_s = !dmem_readyM;
            default:  run_s      = 1'b0;
        endcase
    end

    assign start_s   = run_s && mduE;
    assign mdu_start = start_s && reset;
    assign stallF    = mem_hold_s || mdu_hold_s || start_s || (run_s && lwstall_s);
    assign stallD    = stallF;
    assign stallE    = mem_hold_s || mdu_hold_s || start_s;
    assign stallM    = mem_hold_s;
    assign flushD    = run_s && pcsrcE;
    assign flushE    = run_s && (pcsrcE || lwstall_s);
    assign flushM    = mdu_hold_s || start_s;
    assign flushW    = mem_hold_s;

    fwd_unit #(.REG_AW(REG_AW)) u_fwd_a (
        .rs_e       (rs1E),
        .rd_m       (rdM),
        .rd_w       (rdW),
        .regwrite_m (regwriteM),
        .regwrite_w (regwriteW),
        .sel        (fwdAE)
    );

    fwd_unit #(.REG_AW(REG_AW)) u_fwd_b (
        .rs_e       (rs2E),
        .rd_m       (rdM),
        .rd_w       (rdW),
        .regwrite_m (regwriteM),
        .regwrite_w (regwriteW),
        .sel        (fwdBE)
    );

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;

    // Free-running, wrapping event counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, stallF};
            flush_cnt_r <= flush_cnt_r + {{(CNT_W-1){1'b0}}, flushD};
        end
    end

    assign stall_cycles = stall_cnt_r;
    assign flush_count  = flush_cnt_r;
`else
    assign stall_cycles = {CNT_W{1'b0}};
    assign flush_count  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed plus randomized bench for hazard_ctrl against a rule-level reference model.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic       loadE, regwriteM, regwriteW, pcsrcE, mduE, mdu_done, dmem_reqM, dmem_readyM;
    logic       mdu_start, stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW;
    logic [1:0] fwdAE, fwdBE;
    logic [31:0] stall_cycles, flush_count;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: "waiting on memory" / "waiting on MDU" flags and event tallies
    bit          m_mem_busy;
    bit          m_mdu_busy;
    logic [31:0] m_stalls;
    logic [31:0] m_flushes;
    string       cur_tag;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk(clk), .reset(reset),
        .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
        .rdE(rdE), .rdM(rdM), .rdW(rdW),
        .loadE(loadE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .pcsrcE(pcsrcE), .mduE(mduE), .mdu_done(mdu_done),
        .dmem_reqM(dmem_reqM), .dmem_readyM(dmem_readyM),
        .mdu_start(mdu_start),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
        .fwdAE(fwdAE), .fwdBE(fwdBE),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Bit order: start, sF, sD, sE, sM, fD, fE, fM, fW
    function automatic logic [8:0] exp_ctrl();
        logic [8:0] r;
        if (m_mem_busy) return dmem_readyM ? 9'b0_0000_0000 : 9'b0_1111_0001;
        if (m_mdu_busy) return mdu_done    ? 9'b0_0000_0000 : 9'b0_1110_0010;
        if (dmem_reqM && !dmem_readyM) return 9'b0_1111_0001;
        r = 9'b0_0000_0000;
        if (loadE && rdE != 5'd0 && (rdE == rs1D || rdE == rs2D)) r = r | 9'b0_1100_0100;
        if (pcsrcE) r = r | 9'b0_0000_1100;
        if (mduE)   r = r | {reset, 8'b1110_0010};
        return r;
    endfunction

    function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
        if (regwriteM && rdM != 5'd0 && rdM == rs) return 2'b10;
        if (regwriteW && rdW != 5'd0 && rdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    // Check the current cycle, then advance the model across the clock edge
    task automatic cycle();
        logic [8:0] e;
        logic [31:0] e_stall, e_flush;
        #1;
        if (!reset) begin
            m_mem_busy = 1'b0;
            m_mdu_busy = 1'b0;
            m_stalls   = 32'd0;
            m_flushes  = 32'd0;
        end
        e = exp_ctrl();
`ifdef HAZARD_PERF_CNT_EN
        e_stall = m_stalls;
        e_flush = m_flushes;
`else
        e_stall = 32'd0;
        e_flush = 32'd0;
`endif
        check({cur_tag, "/ctrl"}, {55'd0, mdu_start, stallF, stallD, stallE, stallM,
                                   flushD, flushE, flushM, flushW}, {55'd0, e});
        check({cur_tag, "/fwdA"}, {62'd0, fwdAE}, {62'd0, exp_fwd(rs1E)});
        check({cur_tag, "/fwdB"}, {62'd0, fwdBE}, {62'd0, exp_fwd(rs2E)});
        check({cur_tag, "/stall_cnt"}, {32'd0, stall_cycles}, {32'd0, e_stall});
        check({cur_tag, "/flush_cnt"}, {32'd0, flush_count}, {32'd0, e_flush});
        @(posedge clk);
        if (reset) begin
            m_stalls  = m_stalls + {31'd0, e[7]};
            m_flushes = m_flushes + {31'd0, e[3]};
            if (m_mem_busy)      m_mem_busy = !dmem_readyM;
            else if (m_mdu_busy) m_mdu_busy = !mdu_done;
            else if (dmem_reqM && !dmem_readyM) m_mem_busy = 1'b1;
            else if (mduE)       m_mdu_busy = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        {rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW} = {7{5'd0}};
        {loadE, regwriteM, regwriteW, pcsrcE, mduE, mdu_done, dmem_reqM} = 7'd0;
        dmem_readyM = 1'b1;
    endtask

    task automatic rand_inputs();
        int kind;
        kind = int'($urandom_range(0, 5));
        loadE  = (kind == 0);
        mduE   = (kind == 1);
        pcsrcE = (kind == 2);
        rs1D = 5'($urandom_range(0, 3)); rs2D = 5'($urandom_range(0, 3));
        rs1E = 5'($urandom_range(0, 3)); rs2E = 5'($urandom_range(0, 3));
        rdE  = 5'($urandom_range(0, 3)); rdM  = 5'($urandom_range(0, 3));
        rdW  = 5'($urandom_range(0, 3));
        regwriteM   = 1'($urandom_range(0, 1));
        regwriteW   = 1'($urandom_range(0, 1));
        mdu_done    = ($urandom_range(0, 3) == 0);
        dmem_reqM   = m_mdu_busy ? 1'b0 : ($urandom_range(0, 2) == 0);
        dmem_readyM = 1'($urandom_range(0, 1));
        reset       = ($urandom_range(0, 99) != 0);
    endtask

    initial begin
        m_mem_busy = 1'b0; m_mdu_busy = 1'b0; m_stalls = 32'd0; m_flushes = 32'd0;
        idle_inputs();
        reset = 1'b0;
        @(negedge clk);
        cur_tag = "reset_idle";  cycle();
        mduE = 1'b1;
        cur_tag = "reset_mdu";   cycle();
        idle_inputs();
        reset = 1'b1;
        cur_tag = "run_idle";    cycle();

        loadE = 1'b1; rdE = 5'd5; rs1D = 5'd5;
        cur_tag = "loaduse";     cycle();
        loadE = 1'b0;
        cur_tag = "loaduse_end"; cycle();
        loadE = 1'b1; rdE = 5'd0; rs1D = 5'd0;
        cur_tag = "loaduse_x0";  cycle();
        idle_inputs();

        pcsrcE = 1'b1;
        cur_tag = "branch";      cycle();
        pcsrcE = 1'b0;
        cur_tag = "branch_end";  cycle();

        mduE = 1'b1;
        cur_tag = "mdu_start";   cycle();
        for (int i = 0; i < 3; i++) begin
            cur_tag = "mdu_wait"; cycle();
        end
        mdu_done = 1'b1;
        cur_tag = "mdu_done";    cycle();
        idle_inputs();
        cur_tag = "mdu_after";   cycle();

        mduE = 1'b1; dmem_reqM = 1'b1; dmem_readyM = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cur_tag = "memwait"; cycle();
        end
        dmem_readyM = 1'b1;
        cur_tag = "mem_ready";   cycle();
        dmem_reqM = 1'b0;
        cur_tag = "mem_mdu_start"; cycle();
        mdu_done = 1'b1;
        cur_tag = "mem_mdu_done"; cycle();
        idle_inputs();

        rs1E = 5'd3; rdM = 5'd3; rdW = 5'd3; regwriteM = 1'b1; regwriteW = 1'b1; rs2E = 5'd0;
        cur_tag = "fwd_m";       cycle();
        regwriteM = 1'b0;
        cur_tag = "fwd_w";       cycle();
        rdM = 5'd0; rdW = 5'd0; regwriteM = 1'b1;
        cur_tag = "fwd_x0";      cycle();
        idle_inputs();

        mduE = 1'b1;
        cur_tag = "rst_mdu_start"; cycle();
        cur_tag = "rst_mdu_wait";  cycle();
        #2 reset = 1'b0;
        cur_tag = "rst_mid_mdu";   cycle();
        mduE = 1'b0; mdu_done = 1'b1; reset = 1'b1;
        cur_tag = "rst_late_done"; cycle();
        idle_inputs();

        for (int i = 0; i < 800; i++) begin
            rand_inputs();
            cur_tag = "random";
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
